// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
//   Bundles the sample-source handshake and the MAC/delay-line control bus of
//   the FIR MAC sequencer.
//   slave  : the sequencer side (takes srdyi/clr_ovr, drives the datapath controls)
//   master : the surrounding side (sample source, datapath, status reader)
//   Signals: srdyi, clr_ovr (to sequencer); sample_we, wr_addr, rd_addr,
//            coeff_sel, sum_rst, sum_en, srdyo, busy, overrun (from sequencer).
interface fir_mac_sequencer_if #(
  parameter int TAP_W = 4
);
  logic             srdyi;
  logic             clr_ovr;
  logic             sample_we;
  logic [TAP_W-1:0] wr_addr;
  logic [TAP_W-1:0] rd_addr;
  logic [TAP_W-1:0] coeff_sel;
  logic             sum_rst;
  logic             sum_en;
  logic             srdyo;
  logic             busy;
  logic             overrun;

  modport slave (
    input  srdyi, clr_ovr,
    output sample_we, wr_addr, rd_addr, coeff_sel,
           sum_rst, sum_en, srdyo, busy, overrun
  );

  modport master (
    output srdyi, clr_ovr,
    input  sample_we, wr_addr, rd_addr, coeff_sel,
           sum_rst, sum_en, srdyo, busy, overrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Control sequencer for a time-multiplexed FIR built around one shared MAC,
//   a circular sample delay line and a coefficient ROM. Each accepted sample is
//   written at the write pointer, the accumulator is cleared, then all NTAPS
//   taps are stepped (tap 0 pairs with the newest sample) and srdyo pulses.
//   Ports:
//     clk          rising-edge clock
//     GlobalReset  asynchronous reset, active low
//     bus          fir_mac_sequencer_if.slave (handshake + datapath controls)
//   All bus outputs are registered and lag the state register by one cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for srdyi
//   LOAD   | write sample to delay line, clear accumulator
//   MAC    | one tap per cycle, k = 0..NTAPS-1
//   DONE   | result valid, advance write pointer
module fir_mac_sequencer #(
  parameter int NTAPS = 16,
  parameter int TAP_W = 4
) (
  input  logic                clk,
  input  logic                GlobalReset,
  fir_mac_sequencer_if.slave  bus
);

  generate
    if (NTAPS < 2 || NTAPS > (1 << TAP_W)) begin : g_bad_ntaps
      $error("fir_mac_sequencer: NTAPS must lie in 2..2**TAP_W");
    end
  endgenerate

  localparam logic [TAP_W-1:0] K_LAST  = TAP_W'(NTAPS - 1);
  localparam logic [TAP_W:0]   NTAPS_X = (TAP_W + 1)'(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] k_q, k_d;
  logic [TAP_W-1:0] wr_ptr_q, wr_ptr_d;

  logic             sample_we_q, sample_we_d;
  logic             sum_rst_q, sum_rst_d;
  logic             sum_en_q, sum_en_d;
  logic             srdyo_q, srdyo_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [TAP_W-1:0] wr_addr_q, wr_addr_d;
  logic [TAP_W-1:0] rd_addr_q, rd_addr_d;
  logic [TAP_W-1:0] coeff_sel_q, coeff_sel_d;
  logic [TAP_W:0]   rd_diff;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wr_ptr_d    = wr_ptr_q;
    sample_we_d = 1'b0;
    sum_rst_d   = 1'b0;
    sum_en_d    = 1'b0;
    srdyo_d     = 1'b0;
    coeff_sel_d = '0;
    rd_addr_d   = '0;
    wr_addr_d   = wr_ptr_q;
    busy_d      = (state_q != S_IDLE);
    rd_diff     = '0;

    // A sample arriving while busy is dropped; setting beats clearing.
    overrun_d = overrun_q;
    if (bus.clr_ovr) overrun_d = 1'b0;
    if (bus.srdyi && state_q != S_IDLE) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.srdyi) state_d = S_LOAD;
      end
      S_LOAD: begin
        sample_we_d = 1'b1;
        sum_rst_d   = 1'b1;
        k_d         = '0;
        state_d     = S_MAC;
      end
      S_MAC: begin
        sum_en_d    = 1'b1;
        coeff_sel_d = k_q;
        // Walk backwards from the newest sample, wrapping at NTAPS (not 2**TAP_W).
        rd_diff = {1'b0, wr_ptr_q} - {1'b0, k_q};
        if (k_q > wr_ptr_q) rd_diff = rd_diff + NTAPS_X;
        rd_addr_d = rd_diff[TAP_W-1:0];
        if (k_q == K_LAST) state_d = S_DONE;
        else               k_d     = k_q + TAP_W'(1);
      end
      S_DONE: begin
        srdyo_d  = 1'b1;
        wr_ptr_d = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + TAP_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      sample_we_q <= 1'b0;
      sum_rst_q   <= 1'b0;
      sum_en_q    <= 1'b0;
      srdyo_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      coeff_sel_q <= '0;
    end else begin
      sample_we_q <= sample_we_d;
      sum_rst_q   <= sum_rst_d;
      sum_en_q    <= sum_en_d;
      srdyo_q     <= srdyo_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      coeff_sel_q <= coeff_sel_d;
    end
  end

  assign bus.sample_we = sample_we_q;
  assign bus.sum_rst   = sum_rst_q;
  assign bus.sum_en    = sum_en_q;
  assign bus.srdyo     = srdyo_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.coeff_sel = coeff_sel_q;

endmodule
